pwm_multi_ramp: RTL
===================

// Module: pwm_multi_ramp
// PURPOSE
//  Multi-channel motor PWM generator with per-channel direction and slew-limited duty ramping.
//  Drives H-bridge IN/PWM pins; sits between the drive controller and the motor driver pins.
//  Duty changes take effect only at period boundaries (glitch-free).
//  Direction reversals always ramp to zero before flipping dir_out.
// PARAMETERS
//  NUM_CH     2        number of PWM channels
//  PERIOD     100_000  clk_50 cycles per PWM period (500 Hz); must be a multiple of DUTY_MAX
//  DUTY_MAX   100      full-scale duty value (100 = always high)
//  DUTY_W     7        duty command width; must satisfy 2**DUTY_W > DUTY_MAX
//  RAMP_STEP  5        max change in applied duty per period (duty units); >=1
// PORTS
//  clk_50     in   1                 50 MHz clock
//  rst        in   1                 synchronous, active-high reset
//  enable     in   1                 0 = all outputs low, applied duties forced to 0
//  cmd_valid  in   1                 command strobe
//  cmd_ready  out  1                 command can be accepted this cycle
//  cmd_ch     in   $clog2(NUM_CH)    target channel (width min 1)
//  cmd_duty   in   DUTY_W            target duty, 0..DUTY_MAX
//  cmd_dir    in   1                 target direction
//  pwm_out    out  NUM_CH            PWM outputs
//  dir_out    out  NUM_CH            applied direction per channel
//  period_tick out 1                 1-cycle pulse on last cycle of each period
//  busy       out  1                 any channel applied != target (duty or dir)
// BEHAVIOUR
//  Reset: counter=0, pwm_out=0, dir_out=0, period_tick=0, busy=0, cmd_ready=0.
//  Reset also clears all targets/applied duties and returns every channel to RUN.
//  cmd_ready = !rst (registered; 1 from first cycle after reset release).
//  Counter: 0..PERIOD-1, wraps to 0; period_tick=1 when counter==PERIOD-1.
//  Threshold[i] = applied_duty[i] * (PERIOD/DUTY_MAX); updated only on period_tick.
//  pwm_out[i] registered: next cycle = enable && (counter < threshold[i]).
//  Duty 0 -> never high; DUTY_MAX -> high every cycle of period (no 1-cycle glitch at wrap).
//  Command accept on cmd_valid&&cmd_ready: target_duty[ch]=min(cmd_duty,DUTY_MAX), target_dir[ch]=cmd_dir.
//  cmd_ch >= NUM_CH: accepted and discarded.
//  Multiple writes before a tick: last wins.
//  Ramp evaluation on period_tick uses target values held before any same-cycle write;
//    a write in that cycle affects the next tick.
//  Per-channel FSM, evaluated only on period_tick:
//    RUN:   dir_out==target_dir; applied moves toward target by <=RAMP_STEP (clamped, no overshoot).
//           target_dir != dir_out -> DECEL.
//    DECEL: applied -= min(RAMP_STEP, applied); when applied==0 at a tick -> FLIP.
//    FLIP:  dir_out <= target_dir (pwm is 0 for this whole period) -> RUN.
//  If target_dir reverts to dir_out during DECEL -> RUN at next tick (no flip).
//  enable=0: pwm_out=0 from next cycle; applied/threshold forced 0; FSM -> RUN.
//    Targets, dir_out, and counter are retained.
//  enable 0->1: ramp restarts from 0.
//  busy registered: OR over channels of (applied!=target_duty || dir_out!=target_dir).
//  rst mid-period: all state cleared at that edge; counter restarts from 0.
// TESTING (bench: PERIOD=100, DUTY_MAX=100, RAMP_STEP=25, NUM_CH=2)
//  Reset -> pwm_out=00, dir_out=00, busy=0; period_tick every 100 cycles, first at counter 99.
//  ch0 duty=100 dir=0 -> applied 25,50,75,100 on successive ticks; final period high 100/100 cycles.
//  ch0 at 50 dir=0, cmd dir=1 duty=50 -> 25,0, FLIP period (dir_out[0] flips, pwm low), then 25,50.
//  cmd_duty=120 -> clamped to 100; cmd_ch=3 with NUM_CH=2 -> accepted, no state change.
//  Write in the same cycle as period_tick -> no ramp change that tick; ramp starts at the following tick.
//  enable=0 mid-period at duty 75 -> pwm_out 0 next cycle; re-enable -> 25,50,75; rst mid-ramp -> all cleared.

Source files
------------

// File: rtl/pwm_multi_ramp_if.sv
// Command channel into pwm_multi_ramp.
//   cmd_valid  command strobe (controller -> PWM block)
//   cmd_ready  command can be accepted this cycle (PWM block -> controller)
//   cmd_ch     target channel
//   cmd_duty   target duty, 0..DUTY_MAX (larger values are clamped by the receiver)
//   cmd_dir    target direction
interface pwm_multi_ramp_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DUTY_W = 7
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CH_W-1:0]   cmd_ch;
   logic [DUTY_W-1:0] cmd_duty;
   logic              cmd_dir;

   modport master (output cmd_valid, output cmd_ch, output cmd_duty, output cmd_dir,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_duty, input  cmd_dir,
                   output cmd_ready);
endinterface

// File: rtl/pwm_multi_ramp.sv
// Multi-channel H-bridge PWM generator with per-channel direction and slew-limited
// duty ramping. Applied duty only changes on the last cycle of a PWM period, and a
// direction reversal always ramps the channel to zero before dir_out flips.
//   clk_50       50 MHz clock
//   rst          synchronous, active-high reset
//   enable       0 = outputs low, applied duties forced to 0
//   cmd          command channel (slave side of pwm_multi_ramp_if)
//   pwm_out      PWM output per channel
//   dir_out      applied direction per channel
//   period_tick  1-cycle pulse on the last cycle of each period
//   busy         some channel's applied duty/direction differs from its target
module pwm_multi_ramp #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned PERIOD    = 100_000,
   parameter int unsigned DUTY_MAX  = 100,
   parameter int unsigned DUTY_W    = 7,
   parameter int unsigned RAMP_STEP = 5
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              enable,
   pwm_multi_ramp_if.slave   cmd,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] dir_out,
   output logic              period_tick,
   output logic              busy
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = $clog2(PERIOD);
   localparam int unsigned THR_W = $clog2(PERIOD + 1);
   localparam int unsigned SCALE = PERIOD / DUTY_MAX;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);
   localparam logic [DUTY_W-1:0] DMAX     = DUTY_W'(DUTY_MAX);

   typedef enum logic [1:0] {ST_RUN, ST_DECEL, ST_FLIP} ch_state_e;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q, tick_d, tick_c;
   logic              ready_q;
   logic              busy_q, busy_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic [NUM_CH-1:0] dir_q, dir_d;
   logic [NUM_CH-1:0] tgt_dir_q, tgt_dir_d;
   ch_state_e         state_q    [NUM_CH];
   ch_state_e         state_d    [NUM_CH];
   logic [DUTY_W-1:0] applied_q  [NUM_CH];
   logic [DUTY_W-1:0] applied_d  [NUM_CH];
   logic [DUTY_W-1:0] tgt_duty_q [NUM_CH];
   logic [DUTY_W-1:0] tgt_duty_d [NUM_CH];
   logic [THR_W-1:0]  thr_q      [NUM_CH];
   logic [THR_W-1:0]  thr_d      [NUM_CH];

   // Move cur toward tgt by at most STEP without overshooting.
   function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt);
      logic [DUTY_W-1:0] r;
      if (tgt > cur) r = ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
      else           r = ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
      return r;
   endfunction

   // Decelerate toward zero by at most STEP.
   function automatic logic [DUTY_W-1:0] dec_step(input logic [DUTY_W-1:0] cur);
      return (cur > STEP) ? (cur - STEP) : '0;
   endfunction

   // Counter, command capture, per-channel ramp FSM, PWM compare and busy.
   always_comb begin
      tick_c    = (cnt_q == CNT_LAST);
      cnt_d     = tick_c ? '0 : (cnt_q + CNT_W'(1));
      tick_d    = (cnt_d == CNT_LAST);
      busy_d    = 1'b0;
      pwm_d     = '0;
      dir_d     = dir_q;
      tgt_dir_d = tgt_dir_q;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]    = state_q[i];
         applied_d[i]  = applied_q[i];
         tgt_duty_d[i] = tgt_duty_q[i];

         // Out-of-range channel numbers match no channel and are dropped.
         if (cmd.cmd_valid && ready_q && (cmd.cmd_ch == CH_W'(i))) begin
            tgt_duty_d[i] = (cmd.cmd_duty > DMAX) ? DMAX : cmd.cmd_duty;
            tgt_dir_d[i]  = cmd.cmd_dir;
         end

         // Ramp evaluation reads the _q targets, so a same-cycle write waits a tick.
         if (!enable) begin
            applied_d[i] = '0;
            state_d[i]   = ST_RUN;
         end else if (tick_c) begin
            case (state_q[i])
               ST_RUN, ST_FLIP: begin
                  // FLIP period is spent at zero with the new direction; it then ramps like RUN.
                  if (tgt_dir_q[i] != dir_q[i]) begin
                     applied_d[i] = dec_step(applied_q[i]);
                     state_d[i]   = ST_DECEL;
                  end else begin
                     applied_d[i] = ramp_to(applied_q[i], tgt_duty_q[i]);
                     state_d[i]   = ST_RUN;
                  end
               end
               ST_DECEL: begin
                  if (tgt_dir_q[i] == dir_q[i]) begin
                     applied_d[i] = ramp_to(applied_q[i], tgt_duty_q[i]);
                     state_d[i]   = ST_RUN;
                  end else if (applied_q[i] == '0) begin
                     dir_d[i]     = tgt_dir_q[i];
                     state_d[i]   = ST_FLIP;
                  end else begin
                     applied_d[i] = dec_step(applied_q[i]);
                  end
               end
               default: state_d[i] = ST_RUN;
            endcase
         end

         thr_d[i] = THR_W'(applied_d[i]) * THR_W'(SCALE);
         // Threshold == PERIOD keeps the output high through the wrap.
         pwm_d[i] = enable && (THR_W'(cnt_q) < thr_q[i]);
         busy_d   = busy_d | (applied_q[i] != tgt_duty_q[i]) | (dir_q[i] != tgt_dir_q[i]);
      end
   end

   // State registers.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         pwm_q     <= '0;
         dir_q     <= '0;
         tgt_dir_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]    <= ST_RUN;
            applied_q[i]  <= '0;
            tgt_duty_q[i] <= '0;
            thr_q[i]      <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         ready_q   <= 1'b1;
         busy_q    <= busy_d;
         pwm_q     <= pwm_d;
         dir_q     <= dir_d;
         tgt_dir_q <= tgt_dir_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]    <= state_d[i];
            applied_q[i]  <= applied_d[i];
            tgt_duty_q[i] <= tgt_duty_d[i];
            thr_q[i]      <= thr_d[i];
         end
      end
   end

   assign cmd.cmd_ready = ready_q;
   assign pwm_out       = pwm_q;
   assign dir_out       = dir_q;
   assign period_tick   = tick_q;
   assign busy          = busy_q;

endmodule
